// File: rtl/packet_switch_pkg.sv
// Shared helpers for the NxN packet switch: destination-width derivation and
// packed-bus slice offsets.
package packet_switch_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  function automatic int lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/switch_fifo.sv
// Per-input packet queue; pointers carry one extra wrap bit so full and empty
// are both decoded from registered state only.
module switch_fifo
  import packet_switch_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int QDEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = clog2(QDEPTH);

  logic [AW:0]       wp, rp;
  logic [DATA_W-1:0] mem [QDEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end

  // Storage needs no reset: empty pointers make stale entries unreachable.
  always_ff @(posedge clock) begin
    if (push && !full) mem[wp[AW-1:0]] <= din;
  end

  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = (wp == rp);
  assign head  = mem[rp[AW-1:0]];

endmodule

// File: rtl/packet_switch_nxn.sv
// NxN input-queued packet switch: per-input FIFOs, per-output round-robin
// arbitration, registered output stage and contention flag.
module packet_switch_nxn
  import packet_switch_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int DATA_W = 8,
  parameter int QDEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NPORTS-1:0]        in_valid,
  input  logic [NPORTS*DATA_W-1:0] in_data,
  output logic [NPORTS-1:0]        in_ready,
  output logic [NPORTS-1:0]        out_valid,
  output logic [NPORTS*DATA_W-1:0] out_data,
  input  logic [NPORTS-1:0]        out_ready,
  output logic [NPORTS-1:0]        out_collision
);

  localparam int DEST_W = clog2(NPORTS);

  logic [NPORTS-1:0]              full, empty, push, pop;
  logic [NPORTS-1:0][DATA_W-1:0]  head, odata;
  logic [NPORTS-1:0][NPORTS-1:0]  req;
  logic [NPORTS-1:0][DEST_W-1:0]  rr, gidx;
  logic [NPORTS-1:0]              gnt, ovalid, coll, coll_nxt;
  logic [DEST_W-1:0]              idx;

  assign in_ready = ~full;
  assign push     = in_valid & in_ready;

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    switch_fifo #(
      .DATA_W (DATA_W),
      .QDEPTH (QDEPTH)
    ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (in_data[lsb(i, DATA_W) +: DATA_W]),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (head[i])
    );
    assign out_data[lsb(i, DATA_W) +: DATA_W] = odata[i];
  end

  // Descending search so the candidate nearest rr[o] is the last to overwrite.
  always_comb begin
    req      = '0;
    gnt      = '0;
    gidx     = '0;
    pop      = '0;
    coll_nxt = '0;
    idx      = '0;
    for (int o = 0; o < NPORTS; o++) begin
      for (int i = 0; i < NPORTS; i++) begin
        req[o][i] = !empty[i] && (head[i][DEST_W-1:0] == DEST_W'(o));
      end
      coll_nxt[o] = |(req[o] & (req[o] - 1'b1));
      if (!ovalid[o] || out_ready[o]) begin
        for (int k = NPORTS - 1; k >= 0; k--) begin
          idx = rr[o] + DEST_W'(k);
          if (req[o][idx]) begin
            gnt[o]  = 1'b1;
            gidx[o] = idx;
          end
        end
      end
      if (gnt[o]) pop[gidx[o]] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr     <= '0;
      ovalid <= '0;
      odata  <= '0;
      coll   <= '0;
    end else begin
      coll <= coll_nxt;
      for (int o = 0; o < NPORTS; o++) begin
        if (gnt[o]) begin
          ovalid[o] <= 1'b1;
          odata[o]  <= head[gidx[o]];
          rr[o]     <= gidx[o] + DEST_W'(1);
        end else if (out_ready[o]) begin
          ovalid[o] <= 1'b0;
        end
      end
    end
  end

  assign out_valid     = ovalid;
  assign out_collision = coll;

endmodule

// File: tb/tb_packet_switch_nxn.sv
// Scoreboard bench for packet_switch_nxn (4 ports, 8-bit packets, depth 4).
module tb_packet_switch_nxn;

  localparam int N = 4;
  localparam int W = 8;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   in_valid = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_ready;
  logic [N-1:0]   out_valid;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_ready = '0;
  logic [N-1:0]   out_collision;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] txq   [N][$];
  logic [W-1:0] exp_q [N][$];
  logic [N-1:0] fire_in = '0;
  int           acc_cnt [N];

  always #5 clock = ~clock;

  packet_switch_nxn #(.NPORTS(N), .DATA_W(W), .QDEPTH(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .out_collision (out_collision)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_pkt(input int p, input logic [W-1:0] d);
    txq[p].push_back(d);
    exp_q[d[1:0]].push_back(d);
  endtask

  function automatic int pending();
    int n;
    n = 0;
    for (int i = 0; i < N; i++) n += txq[i].size() + exp_q[i].size();
    return n;
  endfunction

  // Input driver: offer queue fronts, retire them on an observed handshake.
  always @(negedge clock) fire_in = in_valid & in_ready & {N{~reset}};

  always @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (fire_in[i] && txq[i].size() > 0) begin
        void'(txq[i].pop_front());
        acc_cnt[i]++;
      end
    end
    #1;
    for (int i = 0; i < N; i++) begin
      in_valid[i]      = (txq[i].size() > 0);
      in_data[i*W +: W] = (txq[i].size() > 0) ? txq[i][0] : '0;
    end
  end

  // Output monitor: each accepted output beat must match the scoreboard head.
  always @(negedge clock) begin
    if (!reset) begin
      for (int o = 0; o < N; o++) begin
        if (out_valid[o] && out_ready[o]) begin
          chk($sformatf("sb_has_%0d", o), 32'(exp_q[o].size() != 0), 32'd1);
          if (exp_q[o].size() != 0)
            chk($sformatf("out_data_%0d", o), 32'(out_data[o*W +: W]), 32'(exp_q[o].pop_front()));
        end
      end
    end
  end

  task automatic apply_reset();
    @(posedge clock);
    #2 reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      txq[i].delete();
      exp_q[i].delete();
      acc_cnt[i] = 0;
    end
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 300; c++) begin
      if (pending() == 0) break;
      @(posedge clock);
    end
    chk(tag, 32'(pending()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    apply_reset();
    @(posedge clock);
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'hF);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_coll", 32'(out_collision), 32'h0);

    // single packet, latency and isolation
    out_ready = '1;
    @(negedge clock);
    push_pkt(0, 8'hA2);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    chk("single_early", 32'(out_valid), 32'h0);
    @(posedge clock);
    @(negedge clock);
    chk("single_valid", 32'(out_valid), 32'h4);
    chk("single_data", 32'(out_data[2*W +: W]), 32'hA2);
    drain("single_drain");

    // four-way contention on output 1
    apply_reset();
    out_ready = '1;
    @(negedge clock);
    push_pkt(0, 8'h11);
    push_pkt(1, 8'h21);
    push_pkt(2, 8'h31);
    push_pkt(3, 8'h41);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("cont_valid", 32'(out_valid), 32'h2);
    chk("cont_coll_hi", 32'(out_collision[1]), 32'h1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("cont_coll_lo", 32'(out_collision[1]), 32'h0);
    drain("cont_drain");

    // backpressure on output 3
    apply_reset();
    out_ready = 4'b0111;
    @(negedge clock);
    for (int s = 0; s < 6; s++) push_pkt(2, {2'd2, 4'(s), 2'd3});
    repeat (12) @(posedge clock);
    @(negedge clock);
    chk("bp_in_ready", 32'(in_ready[2]), 32'h0);
    chk("bp_accepted", 32'(acc_cnt[2]), 32'd5);
    chk("bp_held_valid", 32'(out_valid[3]), 32'h1);
    chk("bp_held_data", 32'(out_data[3*W +: W]), 32'h83);
    out_ready = '1;
    drain("bp_drain");

    // fairness between ports 0 and 3 on output 0
    apply_reset();
    out_ready = '1;
    @(negedge clock);
    for (int s = 0; s < 6; s++) begin
      push_pkt(0, {2'd0, 4'(s), 2'd0});
      push_pkt(3, {2'd3, 4'(s), 2'd0});
    end
    drain("fair_drain");

    // permutation: every output granted in the same cycle
    apply_reset();
    out_ready = '1;
    @(negedge clock);
    push_pkt(0, 8'h53);
    push_pkt(1, 8'h62);
    push_pkt(2, 8'h71);
    push_pkt(3, 8'h80);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("perm_early", 32'(out_valid), 32'h0);
    @(posedge clock);
    @(negedge clock);
    chk("perm_valid", 32'(out_valid), 32'hF);
    chk("perm_coll", 32'(out_collision), 32'h0);
    drain("perm_drain");

    // mid-operation reset discards everything in flight
    apply_reset();
    out_ready = '0;
    @(negedge clock);
    push_pkt(0, 8'h05);
    push_pkt(0, 8'h09);
    push_pkt(1, 8'h45);
    push_pkt(1, 8'h49);
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("mid_valid_pre", 32'(out_valid[1]), 32'h1);
    chk("mid_coll_pre", 32'(out_collision[1]), 32'h1);
    @(posedge clock);
    #2 reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      txq[i].delete();
      exp_q[i].delete();
    end
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_data", out_data, 32'h0);
    chk("mid_rst_coll", 32'(out_collision), 32'h0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    @(posedge clock);
    #2;
    chk("mid_in_ready", 32'(in_ready), 32'hF);
    out_ready = '1;
    repeat (15) @(posedge clock);
    @(negedge clock);
    chk("mid_no_stale", 32'(out_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
